note_sequencer: RTL
===================

# note_sequencer

Plays a song stored as note/duration records in a synchronous song ROM and drives the tone generator with one `fullnote` code at a time. It sits directly upstream of the square-wave tone generator. It replaces the free-running address counter with tempo-accurate durations, play/pause/restart control and an articulation gap. Each ROM word holds a duration field in beats and the 8-bit `fullnote` code (0 = rest); a duration of 0 marks end of song.

## Interface
- `ADDR_W`, 8: song ROM address width.
- `TICK_DIV`, 1562500: clocks per tick; must be ≥ 2.
- `BEAT_TICKS`, 16: ticks per beat.
- `GAP_TICKS`, 1: muted ticks at the start of each note; must be < `BEAT_TICKS`.
- `clk`  in  1  system clock; all logic on rising edge.
- `rst`  in  1  asynchronous, active-high reset.
- `play`  in  1  level; high = run, low = pause.
- `restart`  in  1  one-cycle pulse; restart the song from address 0.
- `rom_addr`  out  ADDR_W  registered song ROM address.
- `rom_data`  in  12  ROM word: [11:8] duration in beats, [7:0] fullnote; valid one cycle after `rom_addr` changes.
- `fullnote`  out  8  note code to the tone generator.
- `note_on`  out  1  high = tone generator may sound `fullnote`.
- `busy`  out  1  high in every state except IDLE.
- `song_done`  out  1  one-cycle pulse at end of song.

## Operation
- Reset values: state IDLE, `rom_addr`=0, `fullnote`=0, `note_on`=0, `busy`=0, `song_done`=0, all counters 0.
- **IDLE**
  - `play`=1 → FETCH.
  - `rom_addr` stays at its current value (0 after reset or end of song).
- **FETCH** (1 cycle)
  - `rom_addr` is held stable; → WAIT.
- **WAIT** (1 cycle)
  - `rom_data` is sampled at the end of this cycle.
  - Duration 0 → end handling.
  - Otherwise load `fullnote`, load the remaining-tick counter with duration×`BEAT_TICKS`, clear the prescaler, → PLAY.
- **PLAY**
  - The prescaler counts only while `play`=1.
  - A tick strobe fires when the prescaler reaches `TICK_DIV`-1, then the prescaler wraps to 0.
  - Each tick decrements the remaining-tick counter.
  - On the tick that brings the counter to 0: `rom_addr`+1 (wraps at 2^ADDR_W to 0) → FETCH.
- `note_on` = (state==PLAY) & `play` & (elapsed ticks in this note ≥ `GAP_TICKS`) & (`fullnote`≠0).
  - `note_on` is registered and low in FETCH, WAIT and IDLE.
- **Pause:** `play`=0 in PLAY freezes the prescaler and tick counters and holds `fullnote`; `note_on` drops the next cycle. On resume, counting continues from the frozen values.
- **Pause elsewhere:** `play`=0 in FETCH or WAIT does not stall the fetch; the block enters PLAY frozen.
- **End handling:** `song_done` pulses in the cycle after WAIT; `fullnote` is set to 0; `rom_addr` is set to 0; behaviour then depends on `SEQ_LOOP_EN` (see Configuration).
- **`restart`**
  - From any state: `rom_addr`=0, `fullnote`=0, `note_on`=0, → FETCH next cycle.
  - `restart` has priority over end handling and over the note-end tick in the same cycle; `song_done` is suppressed.
  - `restart` in IDLE starts playback regardless of `play`.
- Arithmetic: the remaining-tick counter is 4+clog2(`BEAT_TICKS`) bits wide; the prescaler is clog2(`TICK_DIV`) bits wide; no saturation is needed.
- `rst` mid-note returns everything to the reset values immediately, without waiting for a clock edge.

## Timing
- Note-to-note latency: 2 cycles (FETCH, WAIT) between the last PLAY cycle and the next PLAY cycle, with `note_on` low during both.
- Note length while unpaused: duration×`BEAT_TICKS`×`TICK_DIV` + 2 clocks per record.
- `note_on` rises 1 cycle after the `GAP_TICKS`-th tick of the note.
- `song_done` fires 3 cycles after the last note's final tick.

## Configuration
- `SEQ_LOOP_EN` defined: after end handling → FETCH from address 0; playback loops indefinitely while `play`=1, and `song_done` still pulses once per pass.
- `SEQ_LOOP_EN` undefined: after end handling → IDLE with `busy`=0. `play` must go low and then high again to replay; a level held high does not retrigger.
  - Implement this with a registered `play` edge detector that is compiled in only in this mode.

## Structure
- Shared package `music_pkg` holds:
  - the state enum (IDLE, FETCH, WAIT, PLAY);
  - ROM field positions `DUR_MSB`=11, `DUR_LSB`=8, `NOTE_MSB`=7;
  - the end-of-song duration constant 0;
  - the rest code 0.
  The tone generator also imports this package for the rest code.
- One sub-module, `tick_prescaler`: inputs `clk`, `rst`, `en`, `clr`; output single-cycle `tick`; parameter `TICK_DIV`.

## Test plan
Parameters for all scenarios: `TICK_DIV`=4, `BEAT_TICKS`=4, `GAP_TICKS`=1. ROM contents: addr0={dur 2, note 0x15}, addr1={dur 1, note 0x00}, addr2={dur 0}.
1. Reset then `play`=1 → `rom_addr` 0 in FETCH; `fullnote`=0x15 on the 3rd cycle; `note_on` high from cycle 7 for 28 cycles; `note_on` low after 32 PLAY cycles.
2. Rest record at addr1 → `fullnote`=0 and `note_on` stays low for 16 PLAY cycles; then `song_done` is a single-cycle pulse and `fullnote`=0. Without `SEQ_LOOP_EN`: `busy`=0. With `SEQ_LOOP_EN`: `rom_addr` returns to 0 and 0x15 replays.
3. `play`=0 for 10 cycles mid-note at addr0 → `note_on` low the next cycle and counters frozen; total note time becomes 32+10 cycles.
4. `restart` pulsed in the same cycle as addr0's final tick → `song_done` never fires; FETCH of addr 0; note 0x15 replays with full duration.
5. `rst` asserted asynchronously mid-PLAY → all outputs at reset values before the next edge; no `song_done` pulse.
6. ROM filled with dur=1 records at all 256 addresses, `SEQ_LOOP_EN` undefined → `rom_addr` wraps from 255 to 0 and plays continuously; `song_done` never asserts.

Source files
------------

// File: rtl/music_pkg.sv
// music_pkg: definitions shared by the note sequencer and the tone generator.
//   - seq_state_t : sequencer FSM states (IDLE, FETCH, WAIT, PLAY)
//   - song ROM word layout: [11:8] duration in beats, [7:0] fullnote code
//   - END_DUR     : duration value that marks the end of the song
//   - REST_NOTE   : fullnote code for silence
package music_pkg;

    typedef enum logic [1:0] {
        IDLE  = 2'd0,
        FETCH = 2'd1,
        WAIT  = 2'd2,
        PLAY  = 2'd3
    } seq_state_t;

    localparam int DUR_MSB  = 11;
    localparam int DUR_LSB  = 8;
    localparam int NOTE_MSB = 7;

    localparam logic [3:0] END_DUR   = 4'd0;
    localparam logic [7:0] REST_NOTE = 8'd0;

    function automatic logic [3:0] rom_dur(input logic [11:0] word);
        return word[DUR_MSB:DUR_LSB];
    endfunction

    function automatic logic [7:0] rom_note(input logic [11:0] word);
        return word[NOTE_MSB:0];
    endfunction

endpackage

// File: rtl/note_sequencer_if.sv
// note_sequencer_if: control, song-ROM and tone-generator signals of the
// note sequencer.
//   play      : level, high = run, low = pause
//   restart   : one-cycle pulse, restart the song from address 0
//   rom_addr  : registered song ROM address
//   rom_data  : ROM word, valid one cycle after rom_addr changes
//   fullnote  : note code to the tone generator
//   note_on   : tone generator may sound fullnote
//   busy      : sequencer is not idle
//   song_done : one-cycle pulse at end of song
//   state_dbg : current sequencer FSM state
//
// Signalling contract: there is no valid/ready pair here. play is a level
// sampled every clock; restart and song_done are single-cycle strobes that
// are acted on in the cycle they are high; rom_data is trusted exactly one
// cycle after rom_addr settles (synchronous ROM), which the FETCH state covers.
// Modports: master = sequencer side, slave = environment (ROM, controller).
interface note_sequencer_if
    import music_pkg::*;
#(
    parameter int ADDR_W = 8
);
    logic              play;
    logic              restart;
    logic [ADDR_W-1:0] rom_addr;
    logic [11:0]       rom_data;
    logic [7:0]        fullnote;
    logic              note_on;
    logic              busy;
    logic              song_done;
    seq_state_t        state_dbg;

    modport master (
        input  play, restart, rom_data,
        output rom_addr, fullnote, note_on, busy, song_done, state_dbg
    );

    modport slave (
        output play, restart, rom_data,
        input  rom_addr, fullnote, note_on, busy, song_done, state_dbg
    );
endinterface

// File: rtl/note_sequencer_tick_prescaler.sv
// tick_prescaler: divides the system clock into tick strobes.
//   clk  : system clock
//   rst  : asynchronous active-high reset
//   en   : count enable; the count is frozen while low
//   clr  : synchronous clear of the count (wins over en)
//   tick : single-cycle strobe when the count reaches TICK_DIV-1 while enabled
// TICK_DIV must be at least 2.
module tick_prescaler #(
    parameter int TICK_DIV = 1562500
) (
    input  logic clk,
    input  logic rst,
    input  logic en,
    input  logic clr,
    output logic tick
);
    localparam int CW = $clog2(TICK_DIV);

    logic [CW-1:0] cnt;

    assign tick = en & ~clr & (cnt == CW'(TICK_DIV - 1));

    always_ff @(posedge clk or posedge rst) begin
        if (rst) begin
            cnt <= '0;
        end else if (clr) begin
            cnt <= '0;
        end else if (en) begin
            cnt <= tick ? '0 : cnt + CW'(1);
        end
    end
endmodule

// File: rtl/note_sequencer.sv
// note_sequencer: plays note/duration records from a synchronous song ROM and
// drives the tone generator with one fullnote code at a time.
//   clk : system clock, rising edge
//   rst : asynchronous active-high reset
//   bus : note_sequencer_if.master (play, restart, rom_addr, rom_data,
//         fullnote, note_on, busy, song_done, state_dbg)
// Parameters: ADDR_W (ROM address width), TICK_DIV (clocks per tick, >= 2),
// BEAT_TICKS (ticks per beat), GAP_TICKS (muted ticks at note start,
// < BEAT_TICKS).
// Build option SEQ_LOOP_EN: when defined the song loops forever from address
// 0; when undefined the sequencer returns to IDLE at end of song and waits for
// a fresh rising edge of play.
module note_sequencer
    import music_pkg::*;
#(
    parameter int ADDR_W     = 8,
    parameter int TICK_DIV   = 1562500,
    parameter int BEAT_TICKS = 16,
    parameter int GAP_TICKS  = 1
) (
    input logic              clk,
    input logic              rst,
    note_sequencer_if.master bus
);
    // Holds up to 15 beats worth of ticks.
    localparam int RW = 4 + $clog2(BEAT_TICKS);

    seq_state_t        state;
    logic [ADDR_W-1:0] addr;
    logic [7:0]        note;
    logic              note_on_r;
    logic              busy_r;
    logic              done_r;
    logic [RW-1:0]     remaining;
    logic [RW-1:0]     elapsed;
    logic [RW-1:0]     elapsed_inc;

    logic       tick;
    logic       pre_en;
    logic       pre_clr;
    logic       start;
    logic [3:0] w_dur;
    logic [7:0] w_note;

    assign w_dur       = rom_dur(bus.rom_data);
    assign w_note      = rom_note(bus.rom_data);
    assign elapsed_inc = elapsed + RW'(1);

    // Counting only happens while playing and unpaused; every new note and
    // every restart starts the tick period from scratch.
    assign pre_en  = (state == PLAY) & bus.play;
    assign pre_clr = (state == WAIT) | bus.restart;

    tick_prescaler #(
        .TICK_DIV(TICK_DIV)
    ) u_tick_prescaler (
        .clk (clk),
        .rst (rst),
        .en  (pre_en),
        .clr (pre_clr),
        .tick(tick)
    );

`ifdef SEQ_LOOP_EN
    assign start = bus.play;
`else
    // Replaying a finished song needs play to drop and rise again, so a held
    // level cannot retrigger.
    logic play_q;

    always_ff @(posedge clk or posedge rst) begin
        if (rst) begin
            play_q <= 1'b0;
        end else begin
            play_q <= bus.play;
        end
    end

    assign start = bus.play & ~play_q;
`endif

    // note_on is registered: each branch computes the value for the state it
    // moves into, so it lags play by one cycle and is low outside PLAY.
    always_ff @(posedge clk or posedge rst) begin
        if (rst) begin
            state     <= IDLE;
            addr      <= '0;
            note      <= REST_NOTE;
            note_on_r <= 1'b0;
            busy_r    <= 1'b0;
            done_r    <= 1'b0;
            remaining <= '0;
            elapsed   <= '0;
        end else begin
            done_r <= 1'b0;
            if (bus.restart) begin
                // Overrides end handling and the note-end tick.
                state     <= FETCH;
                addr      <= '0;
                note      <= REST_NOTE;
                note_on_r <= 1'b0;
                busy_r    <= 1'b1;
                remaining <= '0;
                elapsed   <= '0;
            end else begin
                case (state)
                    IDLE: begin
                        note_on_r <= 1'b0;
                        if (start) begin
                            state  <= FETCH;
                            busy_r <= 1'b1;
                        end
                    end
                    FETCH: begin
                        note_on_r <= 1'b0;
                        state     <= WAIT;
                    end
                    WAIT: begin
                        if (w_dur == END_DUR) begin
                            done_r    <= 1'b1;
                            note      <= REST_NOTE;
                            addr      <= '0;
                            note_on_r <= 1'b0;
`ifdef SEQ_LOOP_EN
                            state     <= FETCH;
                            busy_r    <= 1'b1;
`else
                            state     <= IDLE;
                            busy_r    <= 1'b0;
`endif
                        end else begin
                            note      <= w_note;
                            remaining <= RW'(w_dur) * RW'(BEAT_TICKS);
                            elapsed   <= '0;
                            state     <= PLAY;
                            note_on_r <= bus.play && (GAP_TICKS == 0) &&
                                         (w_note != REST_NOTE);
                        end
                    end
                    PLAY: begin
                        if (tick) begin
                            remaining <= remaining - RW'(1);
                            elapsed   <= elapsed_inc;
                            if (remaining == RW'(1)) begin
                                addr      <= addr + ADDR_W'(1);
                                state     <= FETCH;
                                note_on_r <= 1'b0;
                            end else begin
                                note_on_r <= bus.play &&
                                             (elapsed_inc >= RW'(GAP_TICKS)) &&
                                             (note != REST_NOTE);
                            end
                        end else begin
                            note_on_r <= bus.play &&
                                         (elapsed >= RW'(GAP_TICKS)) &&
                                         (note != REST_NOTE);
                        end
                    end
                    default: begin
                        state <= IDLE;
                    end
                endcase
            end
        end
    end

    assign bus.rom_addr  = addr;
    assign bus.fullnote  = note;
    assign bus.note_on   = note_on_r;
    assign bus.busy      = busy_r;
    assign bus.song_done = done_r;
    assign bus.state_dbg = state;

endmodule
